approximate_adder_vl: RTL and testbench
=======================================

// Module: approximate_adder_vl
// PURPOSE
//  Parametrised, segmented carry-speculative adder with variable latency. It is the
//  sequential successor of the fixed 8-bit approximate adder.
//  - Each segment's carry-in is speculated from the previous segment alone.
//  - Mispredictions are detected.
//  - Per transaction, the result is either returned approximate (1 cycle) or corrected
//    to exact (2 cycles).
//  - Valid/ready handshake on both sides; sits in datapath pipelines as a drop-in adder stage.
// PARAMETERS
//  WIDTH  16  operand/sum width; must be a multiple of SEG
//  SEG    4   segment width; NSEG = WIDTH/SEG, NSEG >= 2
//  CNT_W  16  width of saturating misprediction counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  cin        in   1      carry-in to segment 0
//  mode       in   1      0 = approximate (1 cycle); 1 = accurate (correct on error)
//  sum        out  WIDTH  registered result
//  cout       out  1      registered carry-out (speculative in approximate result)
//  err        out  1      speculation for this transaction was wrong (approx != exact)
//  corrected  out  1      result went through the correction cycle (exact)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  err_clr    in   1      synchronous clear of err_count
//  err_count  out  CNT_W  saturating count of accepted transactions with err=1
// BEHAVIOUR
//  - Speculation:
//    - Segment 0 adds A[SEG-1:0]+B[SEG-1:0]+cin.
//    - Segment k>=1 uses carry-in = carry-out of segment k-1 computed with carry-in 0
//      (generate only).
//    - Approx {cout,sum} is the concatenation of segment results. Approx cout comes from
//      the top segment with speculated carry-in.
//  - Exact = A+B+cin, WIDTH+1 bits. err = (approx {cout,sum} != exact {cout,sum}).
//  - Reset (async): sum=0, cout=0, err=0, corrected=0, out_valid=0, err_count=0, state=EMPTY.
//  - FSM states:
//    - EMPTY (no result held)
//    - FULL (result held, out_valid=1)
//    - CORRECT (operands latched, computing exact result, out_valid=0)
//  - in_ready = (state==EMPTY) | (state==FULL & out_ready). In CORRECT, in_ready=0.
//  - Accept (in_valid & in_ready):
//    - If mode=0, or err=0: load approx result (equals exact when err=0) with
//      corrected=0; next state FULL. Latency 1.
//    - If mode=1 and err=1: latch A, B, cin; next state CORRECT.
//    - Next cycle in CORRECT: load exact, err=1, corrected=1; next state FULL. Latency 2.
//  - FULL with out_ready and no accept: next state EMPTY, out_valid=0.
//    - Accept in the same cycle as out_ready gives back-to-back throughput of 1/cycle.
//  - FULL without out_ready: outputs held stable; in_ready=0.
//  - err_count:
//    - Increments on every accepted transaction with err=1, at the accept edge, both modes.
//    - Saturates at 2^CNT_W-1.
//    - err_clr wins over a simultaneous increment (count -> 0).
//  - Reset asserted mid-CORRECT or while FULL: the transaction is discarded and the
//    result is never presented.
//  - Inputs are ignored when in_valid=0; A/B/mode are sampled only at accept.
// TESTING  (WIDTH=16, SEG=4 unless stated)
//  - A=0x1234, B=0x4321, cin=0, mode=1
//    -> 1 cycle later: sum=0x5555, cout=0, err=0, corrected=0.
//  - A=0x00FF, B=0x0001, mode=0
//    -> 1 cycle: sum=0x0000, err=1, corrected=0; err_count=1.
//  - Same operands with mode=1
//    -> in_ready=0 for 1 cycle, then sum=0x0100, err=1, corrected=1 at 2 cycles.
//  - A=0xFFFF, B=0x0001, mode=0 -> sum=0xFF00, cout=0, err=1.
//    With mode=1 -> sum=0x0000, cout=1, corrected=1.
//  - Backpressure:
//    - Stream 4 exact transactions with out_ready low for 3 cycles
//      -> sum held, in_ready=0, no loss or duplication.
//    - Then 1/cycle throughput once out_ready=1.
//  - Reset asserted in CORRECT -> out_valid=0 immediately, err_count=0.
//    CNT_W=2: 5 error transactions -> err_count=3; err_clr with error accept -> 0.

Source files
------------

// File: rtl/approximate_adder_vl.sv
// Segmented carry-speculative adder with a valid/ready handshake and variable latency.
// An approximate result comes back in 1 cycle; accurate mode repairs a misprediction in a 2nd cycle.
//
// state     | meaning
// S_EMPTY   | no result held, ready for operands
// S_FULL    | result held, out_valid=1
// S_CORRECT | operands latched, exact result loads next edge
module approximate_adder_vl #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic             corrected,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam int NSEG = WIDTH / SEG;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_CORRECT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;

  logic [WIDTH:0]   w_approx;
  logic [WIDTH:0]   w_exact;
  logic [WIDTH:0]   w_exact_lat;
  logic [SEG:0]     w_seg_full;
  logic [SEG:0]     w_seg_gen;
  logic             w_spec_c;
  logic             w_err;
  logic             w_accept;
  logic             w_fix;

  // Each segment's carry-in is the generate-only carry of the segment below it.
  always_comb begin
    w_approx   = '0;
    w_seg_full = '0;
    w_seg_gen  = '0;
    w_spec_c   = cin;
    for (int k = 0; k < NSEG; k++) begin
      w_seg_full = {1'b0, A[k*SEG +: SEG]} + {1'b0, B[k*SEG +: SEG]} + {{SEG{1'b0}}, w_spec_c};
      w_seg_gen  = {1'b0, A[k*SEG +: SEG]} + {1'b0, B[k*SEG +: SEG]};
      w_approx[k*SEG +: SEG] = w_seg_full[SEG-1:0];
      if (k == NSEG-1) w_approx[WIDTH] = w_seg_full[SEG];
      w_spec_c = w_seg_gen[SEG];
    end
  end

  assign w_exact     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign w_exact_lat = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_err       = (w_approx != w_exact);
  assign w_accept    = in_valid & in_ready;
  assign w_fix       = mode & w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY:   if (w_accept) w_next = w_fix ? S_CORRECT : S_FULL;
      S_FULL: begin
        if (w_accept)       w_next = w_fix ? S_CORRECT : S_FULL;
        else if (out_ready) w_next = S_EMPTY;
      end
      S_CORRECT: w_next = S_FULL;
      default:   w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_EMPTY) | ((r_state == S_FULL) & out_ready);
    out_valid = (r_state == S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      corrected <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
    end else if (r_state == S_CORRECT) begin
      sum       <= w_exact_lat[WIDTH-1:0];
      cout      <= w_exact_lat[WIDTH];
      err       <= 1'b1;
      corrected <= 1'b1;
    end else if (w_accept) begin
      if (w_fix) begin
        r_a   <= A;
        r_b   <= B;
        r_cin <= cin;
      end else begin
        sum       <= w_approx[WIDTH-1:0];
        cout      <= w_approx[WIDTH];
        err       <= w_err;
        corrected <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (w_accept && w_err && (err_count != {CNT_W{1'b1}}))
      err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_approximate_adder_vl.sv
// Bench for approximate_adder_vl: directed cases plus randomized traffic against a
// cycle-level reference model; a second instance with a 2-bit counter checks saturation.
module tb_approximate_adder_vl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, sum;
  logic          cin, mode, cout, err, corrected, err_clr;
  logic [15:0]   err_count;
  logic          in_ready2, out_valid2, cout2, err2, corrected2;
  logic [W-1:0]  sum2;
  logic [1:0]    err_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  approximate_adder_vl #(.WIDTH(W), .SEG(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .cin(cin), .mode(mode), .sum(sum), .cout(cout), .err(err), .corrected(corrected),
    .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr), .err_count(err_count)
  );

  approximate_adder_vl #(.WIDTH(W), .SEG(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B),
    .cin(cin), .mode(mode), .sum(sum2), .cout(cout2), .err(err2), .corrected(corrected2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_clr(err_clr), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: 4-bit segments, segment k carry-in = carry of (a_{k-1}+b_{k-1}), segment 0 uses cin.
  function automatic logic [W:0] f_approx(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int r = 0;
    int ck = int'(c);
    for (int k = 0; k < W/4; k++) begin
      int ak = (int'(a) >> (4*k)) & 15;
      int bk = (int'(b) >> (4*k)) & 15;
      int s  = ak + bk + ck;
      r = r | ((s & 15) << (4*k));
      if (k == W/4 - 1) r = r | ((s >> 4) << W);
      ck = (ak + bk) >> 4;
    end
    return r[W:0];
  endfunction

  function automatic logic [W:0] f_exact(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int r = int'(a) + int'(b) + int'(c);
    return r[W:0];
  endfunction

  // Reference model: what the block holds and whether it is busy correcting.
  logic         m_full, m_corr;
  logic [W:0]   m_val, m_pend;
  logic         m_err, m_cor;
  int           m_cnt, m_cnt2;

  always @(negedge clk) begin
    logic exp_ir, acc, e;
    logic [W:0] ap, ex;
    if (rst) begin
      m_full = 0; m_corr = 0; m_val = '0; m_pend = '0; m_err = 0; m_cor = 0;
      m_cnt = 0; m_cnt2 = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_count", {16'd0, err_count}, 32'd0);
    end else begin
      exp_ir = !m_corr && (!m_full || out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("out_valid2", {31'd0, out_valid2}, {31'd0, m_full});
      if (m_full) begin
        chk("sum_cout", {15'd0, cout, sum}, {15'd0, m_val});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("corrected", {31'd0, corrected}, {31'd0, m_cor});
        if (out_ready) n_deliv++;
      end
      chk("err_count", {16'd0, err_count}, m_cnt);
      chk("err_count2", {30'd0, err_count2}, m_cnt2);

      acc = in_valid && exp_ir;
      ap  = f_approx(A, B, cin);
      ex  = f_exact(A, B, cin);
      e   = (ap != ex);
      if (m_corr) begin
        m_corr = 0; m_full = 1; m_val = m_pend; m_err = 1; m_cor = 1;
      end else if (acc) begin
        if (mode && e) begin
          m_corr = 1; m_full = 0; m_pend = ex;
        end else begin
          m_full = 1; m_val = ap; m_err = e; m_cor = 0;
        end
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
      if (err_clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (acc && e) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic m);
    A = a; B = b; cin = c; mode = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_op(input logic [W-1:0] other);
    case ($urandom_range(0, 3))
      0: return W'($urandom);
      1: return W'($urandom_range(0, 3));
      2: return ~other;
      default: return W'($urandom) | 16'h0F0F;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] bp_a [4] = '{16'h1111, 16'h0101, 16'h3333, 16'h0A0A};
  logic [W-1:0] bp_b [4] = '{16'h2222, 16'h1010, 16'h4444, 16'h0505};

  initial begin
    int idx, base;
    logic acc;
    rst = 1; in_valid = 0; A = '0; B = '0; cin = 0; mode = 0; out_ready = 1; err_clr = 0;
    #1;
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_flags", {28'd0, cout, err, corrected, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst = 0;
    step();

    chk("model_approx_00ff", {15'd0, f_approx(16'h00FF, 16'h0001, 1'b0)}, 32'h00000);
    chk("model_approx_ffff", {15'd0, f_approx(16'hFFFF, 16'h0001, 1'b0)}, 32'h0FF00);

    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    chk("t1_sum", {16'd0, sum}, 32'h5555);
    chk("t1_flags", {28'd0, cout, err, corrected, out_valid}, 32'b0001);
    step();

    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("t2_sum", {16'd0, sum}, 32'h0000);
    chk("t2_flags", {28'd0, cout, err, corrected, out_valid}, 32'b0101);
    chk("t2_count", {16'd0, err_count}, 32'd1);
    step();

    send(16'h00FF, 16'h0001, 1'b0, 1'b1);
    chk("t3_busy", {30'd0, in_ready, out_valid}, 32'b00);
    step();
    chk("t3_sum", {16'd0, sum}, 32'h0100);
    chk("t3_flags", {28'd0, cout, err, corrected, out_valid}, 32'b0111);
    chk("t3_count", {16'd0, err_count}, 32'd2);
    step();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t4_sum", {15'd0, cout, sum}, 32'h0FF00);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_count2", {30'd0, err_count2}, 32'd3);
    step();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step();
    chk("t5_sum", {15'd0, cout, sum}, 32'h10000);
    chk("t5_corr", {31'd0, corrected}, 32'd1);
    step();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("sat_count", {16'd0, err_count}, 32'd5);
    chk("sat_count2", {30'd0, err_count2}, 32'd3);
    step();
    err_clr = 1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    err_clr = 0;
    chk("clr_count", {16'd0, err_count}, 32'd0);
    chk("clr_count2", {30'd0, err_count2}, 32'd0);
    step();

    // Backpressure: out_ready low for the first 3 cycles of a 4-transaction stream.
    idx = 0;
    base = n_deliv;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      A = bp_a[idx % 4]; B = bp_b[idx % 4]; cin = 0; mode = 1;
      out_ready = (c >= 3);
      #1;
      if (c == 1 || c == 2) begin
        chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_stall_sum", {16'd0, sum}, 32'h3333);
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 0;
    step();
    chk("bp_delivered", n_deliv - base, 32'd4);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = W'($urandom);
      B         = rnd_op(A);
      cin       = 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid = 0; err_clr = 0; out_ready = 1;
    step(); step();

    // Reset while correcting: the result must never appear.
    send(16'h00FF, 16'h0001, 1'b0, 1'b1);
    rst = 1;
    #1;
    chk("rstc_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstc_count", {16'd0, err_count}, 32'd0);
    step();
    rst = 0;
    step();
    chk("rstc_not_presented", {31'd0, out_valid}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
